uart_rx_parity_chk: RTL

Parametrised serial parity checker for the UART receive path. It accumulates parity bit by bit as the data sampler strobes each data bit. It then compares the result against the sampled parity bit and reports a per-frame error, a sticky error and a saturating error count. It replaces the fixed 8-bit, parallel-data checker and adds mark/space parity, a length check and error statistics.

---
 rtl/uart_rx_parity_chk_pkg.sv | 34 +++
 rtl/uart_err_counter.sv | 25 ++
 rtl/uart_rx_parity_chk.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_rx_parity_chk_pkg.sv
// Shared UART definitions: parity type codes (also used by the TX parity
// generator), the RX parity checker state encoding and a parity helper.
package uart_rx_parity_chk_pkg;

  // Parity type codes carried on par_typ
  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Parity checker FSM encoding; visible on the fsm_state debug output
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_WAIT_PAR = 2'd2,
    ST_DONE     = 2'd3
  } par_state_e;

  // Parity bit the transmitter should have sent, given the running XOR of
  // the data bits and the parity type.
  function automatic logic expected_parity(input logic [1:0] typ, input logic acc);
    logic p;
    p = 1'b0;
    case (typ)
      PAR_EVEN:  p = acc;
      PAR_ODD:   p = ~acc;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear. A clear and an increment
// in the same cycle leave the count at 1 (clear first, then count the event).
// Shared by the parity and framing error statistics.
module uart_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_parity_chk.sv
// Serial parity checker for the UART receive path. Data bits are folded into
// a running XOR as the sampler strobes them; the parity bit strobe triggers a
// compare against the expected parity of the latched parity type. Reports a
// per-frame result, a short-frame flag, a sticky error and an error count.
//
// Handshake: frame_start, bit_valid and par_chk_en are single-cycle strobes
// with no back-pressure; each is acted on in the cycle it is high. par_done
// is a one-cycle result strobe with no ready; par_err/len_err are qualified
// by par_done and then held until the next par_done.
module uart_rx_parity_chk
  import uart_rx_parity_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       par_typ,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             par_chk_en,
  input  logic             sampled_bit,
  input  logic             err_clr,
  output logic             par_done,
  output logic             par_err,
  output logic             len_err,
  output logic             par_err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             calc_par,
  output logic [1:0]       fsm_state
);

  // Counter only needs to reach DATA_W-1: the last data bit moves to WAIT_PAR
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  par_state_e      state;
  logic [1:0]      typ_q;
  logic            acc;
  logic [BC_W-1:0] bit_cnt;
  logic            exp_par;
  logic            err_ev;

  // Expected parity follows the running XOR and latched type continuously
  assign exp_par   = expected_parity(typ_q, acc);
  assign calc_par  = exp_par;
  assign fsm_state = state;

  // A reported frame counts as an error event in its par_done cycle
  assign err_ev = par_done & (par_err | len_err);

  // Frame FSM: accumulate data bits, check the parity bit, pulse par_done.
  // frame_start wins over everything, so a new start bit aborts silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      typ_q    <= PAR_EVEN;
      acc      <= 1'b0;
      bit_cnt  <= '0;
      par_done <= 1'b0;
      par_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      par_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (frame_start) begin
            state   <= ST_ACCUM;
            typ_q   <= par_typ;
            acc     <= 1'b0;
            bit_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCUM, ST_WAIT_PAR: begin
          if (frame_start) begin
            state   <= ST_ACCUM;
            typ_q   <= par_typ;
            acc     <= 1'b0;
            bit_cnt <= '0;
          end else if (par_chk_en) begin
            // Parity strobe beats a coincident data strobe
            par_err  <= (sampled_bit != exp_par);
            len_err  <= (state == ST_ACCUM);
            par_done <= 1'b1;
            state    <= ST_DONE;
          end else if (bit_valid && (state == ST_ACCUM)) begin
            acc     <= acc ^ sampled_bit;
            bit_cnt <= bit_cnt + BC_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= ST_WAIT_PAR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: an event in the same cycle as err_clr still sets it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_sticky <= 1'b0;
    end else if (err_ev) begin
      par_err_sticky <= 1'b1;
    end else if (err_clr) begin
      par_err_sticky <= 1'b0;
    end
  end

  uart_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (err_ev),
    .cnt   (err_cnt)
  );

endmodule
